// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the dual-clock FIFO: Gray read pointer, registered empty flag and a
// first-word fall-through output register. Optional read-side level counter under FIFO_RD_LEVEL_EN.
module fifo_read_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] raddr,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [ADDR_SIZE:0]   rlevel
);

  typedef enum logic {
    EMPTY_OUT = 1'b0,
    FULL_OUT  = 1'b1
  } out_state_t;

  out_state_t           state_reg;
  logic [ADDR_SIZE:0]   rbin_reg;
  logic [ADDR_SIZE:0]   rbin_next;
  logic [ADDR_SIZE:0]   rgray_next;
  logic                 fetch;

  assign rvalid     = (state_reg == FULL_OUT);
  // A word leaves memory whenever one is available and the output register is free or draining.
  assign fetch      = !rempty && (!rvalid || rready);
  assign rbin_next  = rbin_reg + {{ADDR_SIZE{1'b0}}, fetch};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin_reg[ADDR_SIZE-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_reg  <= '0;
      rptr      <= '0;
      rempty    <= 1'b1;
      dout      <= '0;
      state_reg <= EMPTY_OUT;
    end else begin
      rbin_reg <= rbin_next;
      rptr     <= rgray_next;
      rempty   <= (rgray_next == rq2_wptr);
      case (state_reg)
        EMPTY_OUT: begin
          if (fetch) begin
            dout      <= rdata;
            state_reg <= FULL_OUT;
          end
        end
        FULL_OUT: begin
          if (fetch) begin
            dout <= rdata;
          end else if (rready) begin
            state_reg <= EMPTY_OUT;
          end
        end
        default: state_reg <= EMPTY_OUT;
      endcase
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_SIZE:0] wbin_s;
  logic [ADDR_SIZE:0] level_reg;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi <= ADDR_SIZE; gi++) begin : g_gray2bin
      assign wbin_s[gi] = ^rq2_wptr[ADDR_SIZE:gi];
    end
  endgenerate

  always_ff @(posedge rclk) begin
    if (rrst) begin
      level_reg <= '0;
    end else begin
      level_reg <= wbin_s - rbin_next;
    end
  end

  assign rlevel = level_reg;
`else
  assign rlevel = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: count-based reference model, in-order scoreboard, directed and random traffic.
// Define FIFO_RD_LEVEL_EN at build time to check the level counter.
module tb_fifo_read_ctrl;
  localparam int DS    = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 1 << AS;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [DS-1:0] rdata;
  logic [AS-1:0] raddr;
  logic [AS:0]   rq2_wptr;
  logic [AS:0]   rptr;
  logic          rempty;
  logic [DS-1:0] dout;
  logic          rvalid;
  logic          rready;
  logic [AS:0]   rlevel;

  logic [DS-1:0] mem [DEPTH];
  assign rdata = mem[raddr];

  fifo_read_ctrl #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .raddr(raddr), .rq2_wptr(rq2_wptr),
    .rptr(rptr), .rempty(rempty), .dout(dout), .rvalid(rvalid), .rready(rready),
    .rlevel(rlevel)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_pass   = 0;

  int w    = 0;   // words written by the bench
  int wpub = 0;   // words visible through rq2_wptr

  // reference model state (word counts, not pointers)
  int            m_rd    = 0;
  bit            m_valid = 0;
  logic [DS-1:0] m_dout  = '0;
  bit            m_empty = 1;
  int            m_level = 0;
  bit            armed   = 0;
  bit            last_valid = 0;
  logic [DS-1:0] last_dout  = '0;
  logic [DS-1:0] exp_q [$];

  function automatic logic [AS:0] gray(input int b);
    logic [AS:0] x;
    x = b[AS:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge rclk);
  endtask

  task automatic write_word(input logic [DS-1:0] v);
    mem[w % DEPTH] = v;
    exp_q.push_back(v);
    w++;
  endtask

  task automatic publish();
    wpub     = w;
    rq2_wptr = gray(wpub);
  endtask

  task automatic do_reset();
    rrst = 1'b1; rready = 1'b0; w = 0; wpub = 0; rq2_wptr = '0;
    step();
    step();
    rrst = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !rvalid; i++) step();
    check("wait_valid", rvalid, 1);
  endtask

  // Model advances on each edge from the inputs seen there; DUT is compared 1 ns later.
  always @(posedge rclk) begin
    bit ra, rs, fe;
    ra = rready;
    rs = rrst;
    if (rs) begin
      armed = 1; m_rd = 0; m_valid = 0; m_dout = '0; m_empty = 1; m_level = 0;
      exp_q.delete();
    end else if (armed) begin
      fe = !m_empty && (!m_valid || ra);
      if (fe) begin
        m_dout  = mem[m_rd % DEPTH];
        m_valid = 1;
        m_rd++;
      end else if (m_valid && ra) begin
        m_valid = 0;
      end
      m_empty = ((m_rd % (2 * DEPTH)) == (wpub % (2 * DEPTH)));
`ifdef FIFO_RD_LEVEL_EN
      m_level = (wpub - m_rd) & (2 * DEPTH - 1);
`else
      m_level = 0;
`endif
    end
    #1;
    if (armed) begin
      if (!rs && last_valid && ra) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          logic [DS-1:0] e;
          e = exp_q.pop_front();
          check("sb_data", last_dout, e);
          $display("accept word %02h (expected %02h) at %0t", last_dout, e, $time);
        end
      end
      check("m_rvalid", rvalid, m_valid);
      check("m_dout",   dout,   m_dout);
      check("m_rempty", rempty, m_empty);
      check("m_rptr",   rptr,   gray(m_rd));
      check("m_raddr",  raddr,  m_rd % DEPTH);
      check("m_rlevel", rlevel, m_level);
      last_valid = rvalid;
      last_dout  = dout;
    end
  end

  initial begin
    int pct;
    rrst = 1'b1; rready = 1'b0; rq2_wptr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // reset values
    do_reset();
    check("rst_rempty", rempty, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rptr",   rptr,   0);
    check("rst_raddr",  raddr,  0);
    check("rst_dout",   dout,   0);
    check("rst_rlevel", rlevel, 0);

    // single word
    write_word(8'hA5);
    publish();
    step();
    check("sw_rempty_fall", rempty, 0);
    check("sw_rvalid_low",  rvalid, 0);
    step();
    check("sw_rvalid", rvalid, 1);
    check("sw_dout",   dout,   8'hA5);
    rready = 1'b1;
    step();
    check("sw_rvalid_done", rvalid, 0);
    check("sw_rempty_done", rempty, 1);
    check("sw_rptr",        rptr,   5'b00001);

    // back-to-back full drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_word(8'h10 + i[7:0]);
    publish();
    rready = 1'b1;
    wait_valid();
    for (int i = 0; i < DEPTH; i++) begin
      check("b2b_dout",   dout,   8'h10 + i);
      check("b2b_rvalid", rvalid, 1);
      if (i == DEPTH - 1) begin
        check("b2b_rempty", rempty, 1);
        check("b2b_raddr",  raddr,  0);
        check("b2b_rptr",   rptr,   5'b11000);
      end
      step();
    end
    check("b2b_rvalid_end", rvalid, 0);

    // backpressure
    do_reset();
    write_word(8'h31); write_word(8'h32); write_word(8'h33);
    publish();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_dout_hold", dout,   8'h31);
      check("bp_raddr",     raddr,  1);
      check("bp_rvalid",    rvalid, 1);
      step();
    end
    rready = 1'b1;
    step();
    check("bp_word1", dout, 8'h32);
    step();
    check("bp_word2", dout, 8'h33);
    step();
    check("bp_drained", rvalid, 0);

    // level counter
    do_reset();
    for (int i = 0; i < 9; i++) write_word(8'h50 + i[7:0]);
    publish();
    step();
    check("lv_rempty", rempty, 0);
`ifdef FIFO_RD_LEVEL_EN
    check("lv_first", rlevel, 9);
`else
    check("lv_first", rlevel, 0);
`endif
    step();
    check("lv_rvalid", rvalid, 1);
`ifdef FIFO_RD_LEVEL_EN
    check("lv_after_fetch", rlevel, 8);
`else
    check("lv_after_fetch", rlevel, 0);
`endif
    step();
`ifdef FIFO_RD_LEVEL_EN
    check("lv_hold", rlevel, 8);
`else
    check("lv_hold", rlevel, 0);
`endif

    // random traffic with lagging pointer publication, many wraps
    do_reset();
    pct = 70;
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) pct = $urandom_range(10, 100);
      rready = ($urandom_range(0, 99) < pct);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        if (w - m_rd < DEPTH) write_word($urandom_range(0, 255));
      end
      if ($urandom_range(0, 2) != 0) publish();
      step();
    end

    // reset while a word is held
    publish();
    rready = 1'b0;
    if (w == m_rd && !m_valid) begin
      write_word(8'hC3);
      publish();
    end
    wait_valid();
    rrst = 1'b1; w = 0; wpub = 0; rq2_wptr = '0;
    step();
    check("mr_rvalid", rvalid, 0);
    check("mr_rptr",   rptr,   0);
    check("mr_rempty", rempty, 1);
    rrst = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
